// File: rtl/inv_substitution_seq_if.sv
// Handshake/state bundle between a producer/consumer and inv_substitution_seq.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs.
//
// Members: in_valid_i/in_ready_o/state_i on the input side, out_valid_o/
// out_ready_i/state_o/err_o on the output side. States are 5 rows x 64 bits,
// row 0 at index 0. The slave modport is the block; master is its user.
interface inv_substitution_seq_if;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [4:0][63:0]  state_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [4:0][63:0]  state_o;
    logic              err_o;

    modport slave (
        input  in_valid_i, state_i, out_ready_i,
        output in_ready_o, out_valid_o, state_o, err_o
    );

    modport master (
        output in_valid_i, state_i, out_ready_i,
        input  in_ready_o, out_valid_o, state_o, err_o
    );
endinterface

// File: rtl/inv_substitution_seq.sv
// Iterative inverse ASCON S-box layer over a 320-bit state, LANES columns per cycle.
// Latency: out_valid_o rises 64/LANES cycles after the accept edge; period 64/LANES+2.
// Backpressure: holds DONE (and state_o) indefinitely while out_ready_i is low.
//
// Ports: clock_i (rising edge), resetb_i (synchronous, active-low),
//        bus (inv_substitution_seq_if.slave) with both handshakes and err_o.
// Option: INV_SUB_SELFCHECK_EN adds a forward S-box check of each updated
//         column; err_o is then the sticky mismatch flag gated by out_valid_o,
//         otherwise err_o is tied low.
module inv_substitution_seq #(
    parameter int LANES = 8     // must divide 64
) (
    input  logic                  clock_i,
    input  logic                  resetb_i,
    inv_substitution_seq_if.slave bus
);
    localparam int NCOL = 64 / LANES;                  // cycles per state
    localparam int CW   = (NCOL > 1) ? $clog2(NCOL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0][63:0] work_q, work_d;
    logic [5:0]       col_idx;
    logic [4:0]       col_in, col_out;

    function automatic logic [4:0] inv_sbox(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h14; 5'h01: y = 5'h1A; 5'h02: y = 5'h07; 5'h03: y = 5'h0D;
            5'h04: y = 5'h00; 5'h05: y = 5'h09; 5'h06: y = 5'h0E; 5'h07: y = 5'h12;
            5'h08: y = 5'h0A; 5'h09: y = 5'h06; 5'h0A: y = 5'h1D; 5'h0B: y = 5'h01;
            5'h0C: y = 5'h19; 5'h0D: y = 5'h15; 5'h0E: y = 5'h13; 5'h0F: y = 5'h1E;
            5'h10: y = 5'h18; 5'h11: y = 5'h16; 5'h12: y = 5'h0B; 5'h13: y = 5'h11;
            5'h14: y = 5'h03; 5'h15: y = 5'h05; 5'h16: y = 5'h1C; 5'h17: y = 5'h1F;
            5'h18: y = 5'h17; 5'h19: y = 5'h1B; 5'h1A: y = 5'h04; 5'h1B: y = 5'h08;
            5'h1C: y = 5'h0F; 5'h1D: y = 5'h0C; 5'h1E: y = 5'h10; default: y = 5'h02;
        endcase
        return y;
    endfunction

`ifdef INV_SUB_SELFCHECK_EN
    logic err_q, err_d;

    function automatic logic [4:0] fwd_sbox(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h04; 5'h01: y = 5'h0B; 5'h02: y = 5'h1F; 5'h03: y = 5'h14;
            5'h04: y = 5'h1A; 5'h05: y = 5'h15; 5'h06: y = 5'h09; 5'h07: y = 5'h02;
            5'h08: y = 5'h1B; 5'h09: y = 5'h05; 5'h0A: y = 5'h08; 5'h0B: y = 5'h12;
            5'h0C: y = 5'h1D; 5'h0D: y = 5'h03; 5'h0E: y = 5'h06; 5'h0F: y = 5'h1C;
            5'h10: y = 5'h1E; 5'h11: y = 5'h13; 5'h12: y = 5'h07; 5'h13: y = 5'h0E;
            5'h14: y = 5'h00; 5'h15: y = 5'h0D; 5'h16: y = 5'h11; 5'h17: y = 5'h18;
            5'h18: y = 5'h10; 5'h19: y = 5'h0C; 5'h1A: y = 5'h01; 5'h1B: y = 5'h19;
            5'h1C: y = 5'h16; 5'h1D: y = 5'h0A; 5'h1E: y = 5'h0F; default: y = 5'h17;
        endcase
        return y;
    endfunction
`endif

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        col_idx = '0;
        col_in  = '0;
        col_out = '0;
`ifdef INV_SUB_SELFCHECK_EN
        err_d   = err_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    work_d = bus.state_i;
                    cnt_d  = '0;
`ifdef INV_SUB_SELFCHECK_EN
                    err_d  = 1'b0;
`endif
                    fsm_d  = RUN;
                end
            end
            RUN: begin
                // Column packing: row 0 is the MSB of the 5-bit S-box word.
                for (int l = 0; l < LANES; l++) begin
                    col_idx = 6'(int'(cnt_q) * LANES + l);
                    col_in  = {work_q[0][col_idx], work_q[1][col_idx], work_q[2][col_idx],
                               work_q[3][col_idx], work_q[4][col_idx]};
                    col_out = inv_sbox(col_in);
                    work_d[0][col_idx] = col_out[4];
                    work_d[1][col_idx] = col_out[3];
                    work_d[2][col_idx] = col_out[2];
                    work_d[3][col_idx] = col_out[1];
                    work_d[4][col_idx] = col_out[0];
`ifdef INV_SUB_SELFCHECK_EN
                    // Re-apply the forward box; it must reproduce the old column.
                    if (fwd_sbox(col_out) != col_in) err_d = 1'b1;
`endif
                end
                if (cnt_q == CW'(NCOL - 1)) fsm_d = DONE;
                else                        cnt_d = cnt_q + CW'(1);
            end
            DONE: begin
                if (bus.out_ready_i) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            work_q <= '0;
`ifdef INV_SUB_SELFCHECK_EN
            err_q  <= 1'b0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            work_q <= work_d;
`ifdef INV_SUB_SELFCHECK_EN
            err_q  <= err_d;
`endif
        end
    end

    // Handshake outputs come from registered state only.
    assign bus.in_ready_o  = (fsm_q == IDLE);
    assign bus.out_valid_o = (fsm_q == DONE);
    assign bus.state_o     = work_q;
`ifdef INV_SUB_SELFCHECK_EN
    assign bus.err_o       = err_q & (fsm_q == DONE);
`else
    assign bus.err_o       = 1'b0;
`endif
endmodule

// File: tb/tb_inv_substitution_seq.sv
// Directed bench for inv_substitution_seq at LANES = 8, 64 and 1.
// Latency: n/a.
// Backpressure: exercises DONE hold with out_ready_i low.
module tb_inv_substitution_seq;
    logic clk;
    logic resetb;
    int   n_chk;
    int   n_pass;

    inv_substitution_seq_if if8 ();
    inv_substitution_seq_if if64 ();
    inv_substitution_seq_if if1 ();

    inv_substitution_seq #(.LANES(8))  u8  (.clock_i(clk), .resetb_i(resetb), .bus(if8));
    inv_substitution_seq #(.LANES(64)) u64 (.clock_i(clk), .resetb_i(resetb), .bus(if64));
    inv_substitution_seq #(.LANES(1))  u1  (.clock_i(clk), .resetb_i(resetb), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rows packed with row 0 in the low 64 bits.
    function automatic logic [319:0] pack(input logic [63:0] r0, r1, r2, r3, r4);
        return {r4, r3, r2, r1, r0};
    endfunction

    function automatic logic [4:0] fwd(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'h00: y = 5'h04; 5'h01: y = 5'h0B; 5'h02: y = 5'h1F; 5'h03: y = 5'h14;
            5'h04: y = 5'h1A; 5'h05: y = 5'h15; 5'h06: y = 5'h09; 5'h07: y = 5'h02;
            5'h08: y = 5'h1B; 5'h09: y = 5'h05; 5'h0A: y = 5'h08; 5'h0B: y = 5'h12;
            5'h0C: y = 5'h1D; 5'h0D: y = 5'h03; 5'h0E: y = 5'h06; 5'h0F: y = 5'h1C;
            5'h10: y = 5'h1E; 5'h11: y = 5'h13; 5'h12: y = 5'h07; 5'h13: y = 5'h0E;
            5'h14: y = 5'h00; 5'h15: y = 5'h0D; 5'h16: y = 5'h11; 5'h17: y = 5'h18;
            5'h18: y = 5'h10; 5'h19: y = 5'h0C; 5'h1A: y = 5'h01; 5'h1B: y = 5'h19;
            5'h1C: y = 5'h16; 5'h1D: y = 5'h0A; 5'h1E: y = 5'h0F; default: y = 5'h17;
        endcase
        return y;
    endfunction

    function automatic logic [319:0] fwd_state(input logic [319:0] s);
        logic [319:0] o;
        logic [4:0]   c, y;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            c = {s[i], s[64+i], s[128+i], s[192+i], s[256+i]};
            y = fwd(c);
            o[i] = y[4]; o[64+i] = y[3]; o[128+i] = y[2]; o[192+i] = y[1]; o[256+i] = y[0];
        end
        return o;
    endfunction

    task automatic set_in(input int w, input logic v, input logic [319:0] s);
        case (w)
            0: begin if8.in_valid_i  = v; if8.state_i  = s; end
            1: begin if64.in_valid_i = v; if64.state_i = s; end
            default: begin if1.in_valid_i = v; if1.state_i = s; end
        endcase
    endtask

    task automatic set_rdy(input int w, input logic r);
        case (w)
            0: if8.out_ready_i = r;
            1: if64.out_ready_i = r;
            default: if1.out_ready_i = r;
        endcase
    endtask

    task automatic get(input int w, output logic ir, output logic ov, output logic er,
                       output logic [319:0] so);
        case (w)
            0: begin ir = if8.in_ready_o; ov = if8.out_valid_o; er = if8.err_o; so = if8.state_o; end
            1: begin ir = if64.in_ready_o; ov = if64.out_valid_o; er = if64.err_o; so = if64.state_o; end
            default: begin ir = if1.in_ready_o; ov = if1.out_valid_o; er = if1.err_o; so = if1.state_o; end
        endcase
    endtask

    // Accept one state and wait (bounded) for out_valid_o; lat counts edges after accept.
    task automatic start_wait(input int w, input logic [319:0] s, output int lat,
                              output logic [319:0] res, output logic er);
        logic ir, ov;
        set_in(w, 1'b1, s);
        tick();
        set_in(w, 1'b0, '0);
        lat = 0;
        get(w, ir, ov, er, res);
        while (!ov && lat < 200) begin
            tick();
            lat++;
            get(w, ir, ov, er, res);
        end
    endtask

    task automatic handshake(input int w);
        set_rdy(w, 1'b1);
        tick();
        set_rdy(w, 1'b0);
    endtask

    logic [319:0] rt_orig, rt_in, res, snap;
    logic         ir, ov, er;
    int           lat;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        resetb = 1'b0;
        for (int w = 0; w < 3; w++) begin
            set_in(w, 1'b0, '0);
            set_rdy(w, 1'b0);
        end
        rt_orig = pack(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hDEADBEEFCAFEF00D,
                       64'h0F0F0F0F0F0F0F0F, 64'h8000000000000001);
        rt_in = fwd_state(rt_orig);

        tick();
        tick();
        get(0, ir, ov, er, res);
        chk("rst_in_ready", {319'd0, ir}, 320'd1);
        chk("rst_out_valid", {319'd0, ov}, 320'd0);
        chk("rst_state", res, 320'd0);
        chk("rst_err", {319'd0, er}, 320'd0);
        resetb = 1'b1;
        tick();

        // All-zero column inverts to 0x14: rows 0 and 2 set.
        start_wait(0, '0, lat, res, er);
        chk("zero_lat", 320'(lat), 320'd8);
        chk("zero_state", res, pack(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0));
        chk("zero_err", {319'd0, er}, 320'd0);
        handshake(0);

        // All-ones column inverts to 0x02: only row 3 set.
        start_wait(0, '1, lat, res, er);
        chk("ones_lat", 320'(lat), 320'd8);
        chk("ones_state", res, pack(64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0));
        chk("ones_err", {319'd0, er}, 320'd0);
        handshake(0);

        start_wait(0, rt_in, lat, res, er);
        chk("rt8_lat", 320'(lat), 320'd8);
        chk("rt8_state", res, rt_orig);
        chk("rt8_err", {319'd0, er}, 320'd0);

        // Stay in DONE with out_ready_i low while the input side churns.
        for (int i = 0; i < 5; i++) begin
            set_in(0, i[0] ? 1'b0 : 1'b1, {10{$urandom}});
            tick();
            get(0, ir, ov, er, snap);
            chk("bp_state", snap, rt_orig);
            chk("bp_in_ready", {319'd0, ir}, 320'd0);
            chk("bp_out_valid", {319'd0, ov}, 320'd1);
        end
        set_in(0, 1'b0, '0);
        handshake(0);
        get(0, ir, ov, er, snap);
        chk("bp_rel_in_ready", {319'd0, ir}, 320'd1);
        chk("bp_rel_out_valid", {319'd0, ov}, 320'd0);

        // Reset when cnt = 3.
        set_in(0, 1'b1, rt_in);
        tick();
        set_in(0, 1'b0, '0);
        tick();
        tick();
        tick();
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        get(0, ir, ov, er, snap);
        chk("mid_rst_in_ready", {319'd0, ir}, 320'd1);
        chk("mid_rst_out_valid", {319'd0, ov}, 320'd0);
        chk("mid_rst_state", snap, 320'd0);
        start_wait(0, '0, lat, res, er);
        chk("post_rst_lat", 320'(lat), 320'd8);
        chk("post_rst_state", res, pack(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0));
        handshake(0);

        start_wait(1, rt_in, lat, res, er);
        chk("rt64_lat", 320'(lat), 320'd1);
        chk("rt64_state", res, rt_orig);
        handshake(1);

        start_wait(2, rt_in, lat, res, er);
        chk("rt1_lat", 320'(lat), 320'd64);
        chk("rt1_state", res, rt_orig);
        chk("rt1_err", {319'd0, er}, 320'd0);
        handshake(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
